// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing accumulator slice:
// window FSM state type and the accumulator width helper.
package sc_pkg;

  localparam int DATAWD = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } acc_state_t;

  // Smallest width that can hold any value 0..maxVal.
  function automatic int count_width(input int maxVal);
    return $clog2(maxVal + 1);
  endfunction

  // Ones counter must hold LANES*WINLEN without wrapping.
  function automatic int acc_width(input int lanes, input int winlen);
    return count_width(lanes * winlen);
  endfunction

endpackage

// File: rtl/sc_popcount.sv
// Combinational population count built as a recursive binary adder tree.
module sc_popcount #(
  parameter int W = 16
) (
  input  logic [W-1:0]             i_bits,
  output logic [$clog2(W+1)-1:0]   o_count
);

  localparam int OW = $clog2(W + 1);

  generate
    if (W == 1) begin : g_leaf
      assign o_count = i_bits;
    end else begin : g_split
      localparam int WL  = W / 2;
      localparam int WH  = W - WL;
      localparam int OWL = $clog2(WL + 1);
      localparam int OWH = $clog2(WH + 1);

      logic [OWL-1:0] w_lo;
      logic [OWH-1:0] w_hi;

      sc_popcount #(.W(WL)) u_lo (
        .i_bits  (i_bits[WL-1:0]),
        .o_count (w_lo)
      );

      sc_popcount #(.W(WH)) u_hi (
        .i_bits  (i_bits[W-1:WL]),
        .o_count (w_hi)
      );

      assign o_count = OW'(w_lo) + OW'(w_hi);
    end
  endgenerate

endmodule

// File: rtl/sc_bi_stream_acc.sv
// Windowed ones counter for bipolar stochastic product lanes; converts the
// window's ones count into a signed bipolar MAC result.
module sc_bi_stream_acc
  import sc_pkg::*;
#(
  parameter int LANES  = 16,
  parameter int WINLEN = 255,
  parameter bit INVERT = 1'b1,
  parameter int ACCWD  = acc_width(LANES, WINLEN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [LANES-1:0]        iLaneEn,
  input  logic [LANES-1:0]        ibit,
  output logic                    busy,
  output logic                    oValid,
  output logic signed [ACCWD:0]   oC,
  output logic [ACCWD-1:0]        oOnes
);

  localparam int CNTWD = count_width(WINLEN);
  localparam int PCWD  = count_width(LANES);

  acc_state_t r_state;
  logic [LANES-1:0]   r_mask;
  logic [CNTWD-1:0]   r_bitCnt;
  logic [ACCWD-1:0]   r_ones;
  logic               r_busy;
  logic               r_valid;
  logic signed [ACCWD:0] r_c;
  logic [ACCWD-1:0]   r_onesOut;

  logic [LANES-1:0]   w_gated;
  logic [PCWD-1:0]    w_hits;
  logic [PCWD-1:0]    w_laneCnt;
  logic [ACCWD:0]     w_full;
  logic [ACCWD:0]     w_twoP;
  logic signed [ACCWD:0] w_result;

  assign w_gated = ibit & r_mask;

  sc_popcount #(.W(LANES)) u_hitCount (
    .i_bits  (w_gated),
    .o_count (w_hits)
  );

  sc_popcount #(.W(LANES)) u_laneCount (
    .i_bits  (r_mask),
    .o_count (w_laneCnt)
  );

  // 2*P may exceed the signed range on its own; the wrapped difference is
  // still exact because the true result lies within +/-LANES*WINLEN.
  assign w_full   = (ACCWD+1)'(w_laneCnt) * (ACCWD+1)'(WINLEN);
  assign w_twoP   = {r_ones, 1'b0};
  assign w_result = INVERT ? $signed(w_full - w_twoP) : $signed(w_twoP - w_full);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mask    <= '0;
      r_bitCnt  <= '0;
      r_ones    <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_c       <= '0;
      r_onesOut <= '0;
    end else begin
      r_valid <= 1'b0;

      if (r_state == DONE) begin
        r_valid   <= 1'b1;
        r_c       <= w_result;
        r_onesOut <= r_ones;
      end

      // A start always wins: it aborts a running window or chains after DONE.
      if (start) begin
        r_state  <= RUN;
        r_mask   <= iLaneEn;
        r_ones   <= '0;
        r_bitCnt <= '0;
        r_busy   <= 1'b1;
      end else begin
        case (r_state)
          RUN: begin
            r_ones   <= r_ones + ACCWD'(w_hits);
            r_bitCnt <= r_bitCnt + 1'b1;
            if (r_bitCnt == CNTWD'(WINLEN - 1)) begin
              r_state <= DONE;
            end
          end
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end
    end
  end

  assign busy   = r_busy;
  assign oValid = r_valid;
  assign oC     = r_c;
  assign oOnes  = r_onesOut;

endmodule
